clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//   Produces the enable that drives clk_gate for one gated clock domain.
//   Collects wake requests from NUM_REQ initiators and gated-domain activity, and raises gate_en.
//   Holds gate_en through a wake-settle window, then grants requests round-robin.
//   Drops gate_en only after IDLE_CYC consecutive idle cycles.
//   Runs on free_clk, the ungated clock, at the boundary between always-on and gated logic.
// PARAMETERS
//   NUM_REQ   4   number of requesters (>=1)
//   WAKE_CYC  2   cycles gate_en is high before grants start (>=1)
//   IDLE_CYC  8   consecutive idle cycles in DRAIN before gate_en drops (>=1)
//   Counter width is derived internally from max(WAKE_CYC, IDLE_CYC).
// PORTS
//   free_clk  in   1        ungated clock; all state is updated on its rising edge
//   reset_n   in   1        synchronous, active-low reset
//   req       in   NUM_REQ  level request; held high until matching ack, dropped the cycle after
//   busy      in   1        gated domain reports in-flight activity
//   force_on  in   1        debug/test override; counts as activity
//   ack       out  NUM_REQ  registered one-hot grant pulse, at most one bit per cycle
//   gate_en   out  1        registered enable to clk_gate; 1 = clock running
//   state_o   out  2        current FSM state (debug)
// BEHAVIOUR
//   Reset (reset_n=0 sampled on an edge), applied in every state including mid-WAKE/DRAIN:
//     state=OFF, gate_en=0, ack=0, counter=0, RR pointer=0.
//   activity = |req | busy | force_on.
//   States (state_o encoding): OFF=0, WAKE=1, ON=2, DRAIN=3.
//   gate_en = (state != OFF), taken directly from the state register; no combinational path from inputs.
//   OFF:
//     activity -> WAKE, counter loaded with WAKE_CYC; otherwise remain in OFF.
//   WAKE:
//     counter decrements each cycle; counter==1 -> ON.
//     Inputs are ignored for transitions; no grants are issued.
//   ON:
//     Grant: among req bits not acked this cycle, pick the first at or after the RR pointer (mod NUM_REQ).
//     The winner's ack bit is set next cycle; the pointer moves to winner+1 mod NUM_REQ.
//     A requester acked in cycle t is masked in cycle t, so a requester held for exactly one extra cycle gets no double grant.
//     Transition: !activity && ack==0 -> DRAIN, counter loaded with IDLE_CYC.
//   DRAIN:
//     gate_en stays 1; no grants are issued.
//     activity -> ON (no re-wake); otherwise the counter decrements.
//     counter==1 with no activity -> OFF.
//     Activity in the same cycle as expiry: ON wins, and gate_en never drops.
//   ack is forced to 0 in every state other than ON.
//   Latency from OFF (req high in cycle 0): gate_en=1 in cycle 1, state ON in cycle WAKE_CYC+1, first ack in cycle WAKE_CYC+2.
//   The DRAIN window lasts exactly IDLE_CYC cycles with gate_en=1.
//   A req that drops before being acked is legal and simply receives no grant.
// TESTING
//   1. reset_n=0 for 3 cycles with req=4'hF, busy=1 -> gate_en=0, ack=0, state_o=0 throughout.
//   2. WAKE_CYC=2, OFF, req=4'b0100 at cycle 0 -> gate_en=1 at cycle 1, state_o=2 at cycle 3,
//      ack=4'b0100 at cycle 4 only.
//   3. ON, pointer=0, req=4'hF, each requester drops the cycle after its ack -> ack=1,2,4,8 on 4 consecutive cycles.
//   4. IDLE_CYC=8, all inputs low after the last ack -> state_o=3 and gate_en=1 for 8 cycles, then gate_en=0, state_o=0.
//   5. busy pulsed on the last DRAIN cycle (counter==1) -> state_o=2 next cycle, gate_en never drops.
//   6. reset_n=0 during WAKE with req held -> next cycle state_o=0, gate_en=0;
//      after release, the wake sequence restarts from cycle 0 timing.

Source files
------------

// File: rtl/clk_gate_ctrl_if.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl_if
//   This interface bundles the request/grant handshake and the gate status
//   between the always-on initiators and the clock-gate controller.
//
//   Signals:
//     req      [NUM_REQ-1:0]  Level wake/service request from each initiator.
//     busy                    The gated domain has in-flight activity.
//     force_on                Debug/test override that counts as activity.
//     ack      [NUM_REQ-1:0]  One-hot grant pulse, registered.
//     gate_en                 Enable to clk_gate; 1 = gated clock running.
//     state_o  [1:0]          Controller FSM state (debug).
//
//   Modports:
//     master  initiator/environment side: drives req/busy/force_on.
//     slave   controller side: drives ack/gate_en/state_o.
// ----------------------------------------------------------------------------
interface clk_gate_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic               busy;
  logic               force_on;
  logic [NUM_REQ-1:0] ack;
  logic               gate_en;
  logic [1:0]         state_o;

  modport master (
    output req,
    output busy,
    output force_on,
    input  ack,
    input  gate_en,
    input  state_o
  );

  modport slave (
    input  req,
    input  busy,
    input  force_on,
    output ack,
    output gate_en,
    output state_o
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl
//   This module produces the enable for the clk_gate cell of one gated clock
//   domain. It runs on the ungated free_clk. Wake requests and gated-domain
//   activity raise gate_en. The clock is then allowed to settle for WAKE_CYC
//   cycles, after which requests are granted round-robin. gate_en drops only
//   after IDLE_CYC consecutive idle cycles in DRAIN.
//
//   Ports:
//     free_clk  in   ungated clock; all state updates on its rising edge
//     reset_n   in   synchronous active-low reset
//     bus       slave modport of clk_gate_ctrl_if:
//                 req/busy/force_on in, ack/gate_en/state_o out
//
//   Parameters:
//     NUM_REQ   number of requesters (>=1)
//     WAKE_CYC  cycles gate_en is high before grants start (>=1)
//     IDLE_CYC  idle cycles spent in DRAIN before gate_en drops (>=1)
// ----------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8
) (
  input  logic           free_clk,
  input  logic           reset_n,
  clk_gate_ctrl_if.slave bus
);

  localparam int MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_ack;

  state_t             w_state_n;
  logic [CW-1:0]      w_cnt_n;
  logic [PW-1:0]      w_ptr_n;
  logic [NUM_REQ-1:0] w_ack_n;
  logic               w_activity;
  logic [NUM_REQ-1:0] w_mask;
  logic [PW:0]        w_pick;
  int                 w_nxt_int;

  // This function does the round-robin search. It returns {found, index} for
  // the first set bit of mask at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                          input logic [PW-1:0]      ptr);
    logic [PW:0]   res;
    logic [PW-1:0] sel;
    int            idx;
    res = {1'b0, {PW{1'b0}}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      sel = idx[PW-1:0];
      if (!res[PW] && mask[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Activity decode and the grant candidate search.
  always_comb begin
    w_activity = (|bus.req) | bus.busy | bus.force_on;
    // A requester acked this cycle still holds req for one more cycle. It is
    // masked so that it does not receive a second grant.
    w_mask     = bus.req & ~r_ack;
    w_pick     = rr_pick(w_mask, r_ptr);
  end

  // Next-state, counter, pointer and grant logic.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ptr_n   = r_ptr;
    w_ack_n   = {NUM_REQ{1'b0}};
    w_nxt_int = 0;
    case (r_state)
      ST_OFF: begin
        if (w_activity) begin
          w_state_n = ST_WAKE;
          w_cnt_n   = CW'(WAKE_CYC);
        end else begin
          w_state_n = ST_OFF;
        end
      end
      ST_WAKE: begin
        // Inputs are ignored while the gated clock settles.
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_n = ST_ON;
        end else begin
          w_state_n = ST_WAKE;
        end
      end
      ST_ON: begin
        if (w_pick[PW]) begin
          w_ack_n[w_pick[PW-1:0]] = 1'b1;
          w_nxt_int = (int'(w_pick[PW-1:0]) + 1) % NUM_REQ;
          w_ptr_n   = w_nxt_int[PW-1:0];
        end else begin
          w_ptr_n = r_ptr;
        end
        // A grant still in flight keeps the controller in ON for one more cycle.
        if (!w_activity && (r_ack == {NUM_REQ{1'b0}})) begin
          w_state_n = ST_DRAIN;
          w_cnt_n   = CW'(IDLE_CYC);
        end else begin
          w_state_n = ST_ON;
        end
      end
      ST_DRAIN: begin
        // Activity goes back to ON. The clock never stopped, so no re-wake is
        // needed. Activity also wins over expiry in the same cycle.
        if (w_activity) begin
          w_state_n = ST_ON;
        end else if (r_cnt == CW'(1)) begin
          w_state_n = ST_OFF;
          w_cnt_n   = {CW{1'b0}};
        end else begin
          w_state_n = ST_DRAIN;
          w_cnt_n   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_n = ST_OFF;
        w_cnt_n   = {CW{1'b0}};
        w_ptr_n   = {PW{1'b0}};
      end
    endcase
  end

  // State, counter, pointer and grant registers with synchronous reset.
  always_ff @(posedge free_clk) begin
    if (!reset_n) begin
      r_state <= ST_OFF;
      r_cnt   <= {CW{1'b0}};
      r_ptr   <= {PW{1'b0}};
      r_ack   <= {NUM_REQ{1'b0}};
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_ack   <= w_ack_n;
    end
  end

  // gate_en is decoded only from the state register, so inputs have no path to it.
  assign bus.gate_en = (r_state != ST_OFF);
  assign bus.ack     = r_ack;
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//   This is the directed testbench for clk_gate_ctrl with NUM_REQ=4,
//   WAKE_CYC=2 and IDLE_CYC=8. Inputs are driven and outputs are sampled
//   1 time unit after each rising edge. "Cycle n" means the interval after
//   the n-th edge counted from the point where the stimulus starts.
// ----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

  logic free_clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [3:0] exp_ack;
  logic [3:0] prev_ack;

  clk_gate_ctrl_if #(.NUM_REQ(4)) bus ();

  clk_gate_ctrl #(
    .NUM_REQ (4),
    .WAKE_CYC(2),
    .IDLE_CYC(8)
  ) dut (
    .free_clk(free_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial free_clk = 1'b0;
  always #5 free_clk = ~free_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge free_clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st,
                            input logic ge, input logic [3:0] ak);
    check_eq({tag, ".state"},   {30'd0, bus.state_o}, {30'd0, st});
    check_eq({tag, ".gate_en"}, {31'd0, bus.gate_en}, {31'd0, ge});
    check_eq({tag, ".ack"},     {28'd0, bus.ack},     {28'd0, ak});
  endtask

  // Enters DRAIN from ON with all inputs low. The bench expects exactly
  // 8 DRAIN cycles with gate_en high, then OFF.
  task automatic drain_to_off(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_outs(tag, 2'd3, 1'b1, 4'd0);
    end
    tick();
    check_outs({tag, ".off"}, 2'd0, 1'b0, 4'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset_n      = 1'b0;
    bus.req      = 4'hF;
    bus.busy     = 1'b1;
    bus.force_on = 1'b0;

    // Test 1: reset held for 3 cycles with activity present.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("rst", 2'd0, 1'b0, 4'd0);
    end

    // Test 2: wake latency from OFF for a single requester.
    reset_n  = 1'b1;
    bus.req  = 4'b0100;
    bus.busy = 1'b0;
    check_outs("wake.c0", 2'd0, 1'b0, 4'd0);
    tick(); check_outs("wake.c1", 2'd1, 1'b1, 4'd0);
    tick(); check_outs("wake.c2", 2'd1, 1'b1, 4'd0);
    tick(); check_outs("wake.c3", 2'd2, 1'b1, 4'd0);
    tick(); check_outs("wake.c4", 2'd2, 1'b1, 4'b0100);
    // req is still held in cycle 4, and the masking prevents a second grant.
    tick(); check_outs("wake.c5", 2'd2, 1'b1, 4'd0);
    bus.req = 4'd0;
    drain_to_off("drain1");

    // Test 3: round-robin over all four requesters from pointer 0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req = 4'hF;
    tick(); tick(); tick();
    check_outs("rr.on", 2'd2, 1'b1, 4'd0);
    prev_ack = 4'd0;
    for (int k = 0; k < 4; k++) begin
      exp_ack = 4'd0;
      exp_ack[k] = 1'b1;
      tick();
      check_eq("rr.ack", {28'd0, bus.ack}, {28'd0, exp_ack});
      // Each requester drops the cycle after its ack.
      bus.req  = bus.req & ~prev_ack;
      prev_ack = exp_ack;
    end
    tick();
    check_outs("rr.done", 2'd2, 1'b1, 4'd0);
    bus.req = 4'd0;

    // Test 4: the full DRAIN window, then the gate drops.
    drain_to_off("drain2");

    // Test 5: busy on the last DRAIN cycle returns to ON without dropping the gate.
    bus.busy = 1'b1;
    tick(); tick(); tick();
    check_outs("busy.on", 2'd2, 1'b1, 4'd0);
    bus.busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_outs("busy.drain", 2'd3, 1'b1, 4'd0);
    end
    bus.busy = 1'b1;
    tick(); check_outs("busy.rescue", 2'd2, 1'b1, 4'd0);
    bus.busy = 1'b0;
    tick(); check_outs("busy.redrain", 2'd3, 1'b1, 4'd0);
    // force_on also counts as activity during DRAIN.
    bus.force_on = 1'b1;
    tick(); check_outs("force.on", 2'd2, 1'b1, 4'd0);
    bus.force_on = 1'b0;
    tick(); check_outs("force.drain", 2'd3, 1'b1, 4'd0);

    // Test 6: reset during WAKE, then the wake sequence restarts.
    reset_n = 1'b0;
    tick();
    check_outs("r6.off", 2'd0, 1'b0, 4'd0);
    reset_n = 1'b1;
    bus.req = 4'b0010;
    tick(); check_outs("r6.wake", 2'd1, 1'b1, 4'd0);
    reset_n = 1'b0;
    tick(); check_outs("r6.rst", 2'd0, 1'b0, 4'd0);
    reset_n = 1'b1;
    tick(); check_outs("r6.c1", 2'd1, 1'b1, 4'd0);
    tick(); check_outs("r6.c2", 2'd1, 1'b1, 4'd0);
    tick(); check_outs("r6.c3", 2'd2, 1'b1, 4'd0);
    tick(); check_outs("r6.c4", 2'd2, 1'b1, 4'b0010);
    bus.req = 4'd0;
    tick(); check_outs("r6.c5", 2'd2, 1'b1, 4'd0);
    tick(); check_outs("r6.c6", 2'd3, 1'b1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
